// File: rtl/io_btn_event.sv
// io_btn_event: per-key press/long-press event capture for active-low debounced buttons.
// Each channel registers its pressed level and raises a sticky press flag on
// every press edge. It also keeps a wrapping press counter. The CPU clears the
// flags with a write-1-to-clear mask.
// Optional feature macro: BTN_LONGPRESS_EN adds a saturating hold timer per key
// and a sticky long-press flag. Without it, o_btn_long is tied to 0.
module io_btn_event #(
  parameter int NUM_BTN       = 4,
  parameter int CNT_W         = 8,
  parameter int LONG_MS       = 1000,
  parameter int CLK_PERIOD_NS = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_BTN-1:0]       i_btn,
  input  logic                     i_clr_we,
  input  logic [NUM_BTN-1:0]       i_clr_mask,
  output logic [NUM_BTN-1:0]       o_btn_level,
  output logic [NUM_BTN-1:0]       o_btn_press,
  output logic [NUM_BTN*CNT_W-1:0] o_btn_cnt,
  output logic [NUM_BTN-1:0]       o_btn_long
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] press_edge;
  logic [NUM_BTN-1:0] clr;

  // A key counts as newly pressed when it reads low now but the registered level
  // still says released. A one-cycle pulse therefore still produces exactly one edge.
  assign press_edge = ~i_btn & ~level;
  assign clr        = {NUM_BTN{i_clr_we}} & i_clr_mask;

  // Registered active-high pressed state, one cycle behind the raw key.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level <= '0;
    end else begin
      level <= ~i_btn;
    end
  end

  // Sticky press flags: a new press always beats a simultaneous CPU clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      press <= '0;
    end else begin
      press <= press_edge | (press & ~clr);
    end
  end

  assign o_btn_level = level;
  assign o_btn_press = press;

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    // Free-running press counter that wraps naturally and is cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt <= '0;
      end else if (press_edge[k]) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign o_btn_cnt[k*CNT_W +: CNT_W] = cnt;
  end

`ifdef BTN_LONGPRESS_EN
  localparam longint LONG_CYC = (longint'(LONG_MS) * 1_000_000) / longint'(CLK_PERIOD_NS);
  localparam int TIM_W = (LONG_CYC < 1) ? 1 : $clog2(LONG_CYC + 1);
  localparam logic [TIM_W-1:0] TIM_MAX = TIM_W'(LONG_CYC);
  localparam logic [TIM_W-1:0] TIM_SET = TIM_W'(LONG_CYC - 1);

  logic [NUM_BTN-1:0] long_hit;
  logic [NUM_BTN-1:0] long_flag;

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_hold
    logic [TIM_W-1:0] timer;

    // Hold timer restarts whenever the key is released. It counts every held
    // cycle and parks at the threshold, so the threshold is hit once per hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        timer <= '0;
      end else if (!level[k]) begin
        timer <= '0;
      end else if (timer != TIM_MAX) begin
        timer <= timer + TIM_W'(1);
      end
    end

    // The flag fires on the edge where the timer steps onto the threshold.
    assign long_hit[k] = level[k] && (timer == TIM_SET);
  end

  // Sticky long-press flags: setting beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      long_flag <= '0;
    end else begin
      long_flag <= long_hit | (long_flag & ~clr);
    end
  end

  assign o_btn_long = long_flag;
`else
  assign o_btn_long = '0;
`endif

endmodule

// File: tb/tb_io_btn_event.sv
// tb_io_btn_event: scoreboard bench for io_btn_event with NUM_BTN=4 and CNT_W=8.
// The DUT uses LONG_MS=1 and CLK_PERIOD_NS=100000, which gives a hold threshold of 10 cycles.
// The long-press expectations depend on whether BTN_LONGPRESS_EN is defined.
module tb_io_btn_event;

  localparam int LONG_CYC = 10;

  typedef struct packed {
    logic [3:0]  level;
    logic [3:0]  press;
    logic [31:0] cnt;
    logic [3:0]  lng;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_btn;
  logic        i_clr_we;
  logic [3:0]  i_clr_mask;
  logic [3:0]  o_btn_level;
  logic [3:0]  o_btn_press;
  logic [31:0] o_btn_cnt;
  logic [3:0]  o_btn_long;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t sb[$];
  exp_t e;

  logic [3:0] m_level, m_press, m_long;
  logic [7:0] m_cnt[4];
  int         m_tim[4];

  io_btn_event #(
    .NUM_BTN(4), .CNT_W(8), .LONG_MS(1), .CLK_PERIOD_NS(100000)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(i_btn), .i_clr_we(i_clr_we),
    .i_clr_mask(i_clr_mask), .o_btn_level(o_btn_level), .o_btn_press(o_btn_press),
    .o_btn_cnt(o_btn_cnt), .o_btn_long(o_btn_long)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic model_clear();
    m_level = '0; m_press = '0; m_long = '0;
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = '0;
      m_tim[k] = 0;
    end
    sb.delete();
  endtask

  // Called at a negedge: apply inputs, push the expected post-edge outputs, advance to the next negedge.
  task automatic cyc(input logic [3:0] btn, input logic we, input logic [3:0] mask);
    i_btn = btn; i_clr_we = we; i_clr_mask = mask;
    for (int k = 0; k < 4; k++) begin
      if (!btn[k] && !m_level[k]) begin
        m_press[k] = 1'b1;
        m_cnt[k]   = m_cnt[k] + 8'd1;
      end else if (we && mask[k]) begin
        m_press[k] = 1'b0;
      end
`ifdef BTN_LONGPRESS_EN
      if (m_level[k] && m_tim[k] == LONG_CYC - 1) m_long[k] = 1'b1;
      else if (we && mask[k]) m_long[k] = 1'b0;
      if (!m_level[k]) m_tim[k] = 0;
      else if (m_tim[k] < LONG_CYC) m_tim[k] = m_tim[k] + 1;
`endif
      m_level[k] = !btn[k];
    end
    sb.push_back('{level: m_level, press: m_press,
                   cnt: {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}, lng: m_long});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset with the given keys, then release it at a later negedge.
  task automatic do_reset(input logic [3:0] btn);
    i_btn = btn; i_clr_we = 1'b0; i_clr_mask = '0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_btn = 4'hF; i_clr_we = 1'b0; i_clr_mask = '0; rst_n = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({o_btn_level, o_btn_press, o_btn_cnt, o_btn_long} !== 44'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got lvl=%h prs=%h cnt=%h long=%h, want all 0",
               o_btn_level, o_btn_press, o_btn_cnt, o_btn_long);
    end
    i_btn = 4'h0;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({o_btn_level, o_btn_press, o_btn_cnt, o_btn_long} !== 44'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_keys_low: got lvl=%h prs=%h cnt=%h long=%h, want all 0",
               o_btn_level, o_btn_press, o_btn_cnt, o_btn_long);
    end
    i_btn = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(4'hF, 1'b0, 4'h0);
      e = sb.pop_front();
      tests_run++;
      if ({o_btn_level, o_btn_press, o_btn_cnt, o_btn_long} !== e) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle cyc %0d: got lvl=%h prs=%h cnt=%h long=%h, want lvl=%h prs=%h cnt=%h long=%h",
                 i, o_btn_level, o_btn_press, o_btn_cnt, o_btn_long, e.level, e.press, e.cnt, e.lng);
      end
    end
  endtask

  task automatic test_single_press();
    int lvl_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      cyc((i < 5) ? 4'hB : 4'hF, 1'b0, 4'h0);
      e = sb.pop_front();
      tests_run++;
      if ({o_btn_level, o_btn_press, o_btn_cnt, o_btn_long} !== e) begin
        tests_failed++;
        $display("[TB] FAIL single_press cyc %0d: got lvl=%h prs=%h cnt=%h long=%h, want lvl=%h prs=%h cnt=%h long=%h",
                 i, o_btn_level, o_btn_press, o_btn_cnt, o_btn_long, e.level, e.press, e.cnt, e.lng);
      end
      if (o_btn_level == 4'h4) lvl_cycles++;
    end
    tests_run++;
    if (lvl_cycles != 5) begin
      tests_failed++;
      $display("[TB] FAIL single_level_len: got %0d cycles, want 5", lvl_cycles);
    end
    tests_run++;
    if (o_btn_press !== 4'h4 || o_btn_cnt !== 32'h0001_0000) begin
      tests_failed++;
      $display("[TB] FAIL single_result: got prs=%h cnt=%h, want prs=4 cnt=00010000", o_btn_press, o_btn_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    for (int p = 0; p < 256; p++) begin
      for (int h = 0; h < 2; h++) begin
        cyc((h == 0) ? 4'hE : 4'hF, 1'b0, 4'h0);
        e = sb.pop_front();
        tests_run++;
        if ({o_btn_level, o_btn_press, o_btn_cnt, o_btn_long} !== e) begin
          tests_failed++;
          $display("[TB] FAIL wrap press %0d phase %0d: got lvl=%h prs=%h cnt=%h long=%h, want lvl=%h prs=%h cnt=%h long=%h",
                   p, h, o_btn_level, o_btn_press, o_btn_cnt, o_btn_long, e.level, e.press, e.cnt, e.lng);
        end
      end
      if (p == 254) begin
        tests_run++;
        if (o_btn_cnt[7:0] !== 8'hFF) begin
          tests_failed++;
          $display("[TB] FAIL wrap_all_ones: got cnt0=%h, want ff", o_btn_cnt[7:0]);
        end
      end
    end
    tests_run++;
    if (o_btn_cnt[7:0] !== 8'h00 || o_btn_press[0] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_result: got cnt0=%h prs0=%b, want cnt0=00 prs0=1", o_btn_cnt[7:0], o_btn_press[0]);
    end
  endtask

  task automatic test_clear_collision();
    logic [3:0] btns[6]  = '{4'hF, 4'hC, 4'hF, 4'hF, 4'hD, 4'hF};
    logic       wes[6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] masks[6] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h3, 4'h0};
    logic [3:0] prs[6]   = '{4'h0, 4'h3, 4'h3, 4'h3, 4'h2, 4'h2};
    for (int i = 0; i < 6; i++) begin
      cyc(btns[i], wes[i], masks[i]);
      e = sb.pop_front();
      tests_run++;
      if ({o_btn_level, o_btn_press, o_btn_cnt, o_btn_long} !== e) begin
        tests_failed++;
        $display("[TB] FAIL collision cyc %0d: got lvl=%h prs=%h cnt=%h long=%h, want lvl=%h prs=%h cnt=%h long=%h",
                 i, o_btn_level, o_btn_press, o_btn_cnt, o_btn_long, e.level, e.press, e.cnt, e.lng);
      end
      tests_run++;
      if (o_btn_press !== prs[i]) begin
        tests_failed++;
        $display("[TB] FAIL collision_flags cyc %0d: got prs=%h, want %h", i, o_btn_press, prs[i]);
      end
    end
  endtask

  // Hold key3 for `hold` cycles, then release for 3; optional clear of bit 3 at cycle clr_at.
  task automatic hold_key3(input string name, input int hold, input int clr_at,
                           output int lvl_rise, output int long_rise);
    lvl_rise = -1; long_rise = -1;
    for (int i = 0; i < hold + 3; i++) begin
      cyc((i < hold) ? 4'h7 : 4'hF, (i == clr_at), 4'h8);
      e = sb.pop_front();
      tests_run++;
      if ({o_btn_level, o_btn_press, o_btn_cnt, o_btn_long} !== e) begin
        tests_failed++;
        $display("[TB] FAIL %s cyc %0d: got lvl=%h prs=%h cnt=%h long=%h, want lvl=%h prs=%h cnt=%h long=%h",
                 name, i, o_btn_level, o_btn_press, o_btn_cnt, o_btn_long, e.level, e.press, e.cnt, e.lng);
      end
      if (lvl_rise < 0 && o_btn_level[3]) lvl_rise = i;
      if (long_rise < 0 && o_btn_long[3]) long_rise = i;
    end
  endtask

  task automatic test_long_press();
    int lr, gr;
    do_reset(4'hF);
    hold_key3("long_hold12", 12, -1, lr, gr);
    tests_run++;
`ifdef BTN_LONGPRESS_EN
    if (lr < 0 || gr - lr != LONG_CYC) begin
      tests_failed++;
      $display("[TB] FAIL long_latency: got level rise %0d long rise %0d, want distance %0d", lr, gr, LONG_CYC);
    end
`else
    if (gr != -1) begin
      tests_failed++;
      $display("[TB] FAIL long_disabled: got long rise at %0d, want never", gr);
    end
`endif
    tests_run++;
    if (o_btn_press !== 4'h8 || o_btn_cnt !== 32'h0100_0000) begin
      tests_failed++;
      $display("[TB] FAIL long_press_count: got prs=%h cnt=%h, want prs=8 cnt=01000000", o_btn_press, o_btn_cnt);
    end
    cyc(4'hF, 1'b1, 4'h8);
    void'(sb.pop_front());
    hold_key3("long_hold9", 9, -1, lr, gr);
    tests_run++;
    if (gr != -1) begin
      tests_failed++;
      $display("[TB] FAIL long_short_hold: got long rise at %0d, want never", gr);
    end
    hold_key3("long_clr_mid", 15, 11, lr, gr);
    tests_run++;
    if (o_btn_long[3] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL long_no_reset: got long3=%b, want 0", o_btn_long[3]);
    end
    hold_key3("long_pre_reset", 6, -1, lr, gr);
    do_reset(4'h7);
    hold_key3("long_after_reset", 12, -1, lr, gr);
    tests_run++;
    if (lr != 0 || o_btn_cnt !== 32'h0100_0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_deassert_press: got level rise %0d cnt=%h, want 0 and 01000000", lr, o_btn_cnt);
    end
`ifdef BTN_LONGPRESS_EN
    tests_run++;
    if (gr - lr != LONG_CYC) begin
      tests_failed++;
      $display("[TB] FAIL long_restart: got level rise %0d long rise %0d, want distance %0d", lr, gr, LONG_CYC);
    end
`endif
  endtask

  // Run each scenario in sequence and report.
  initial begin
    rst_n = 1'b0; i_btn = 4'hF; i_clr_we = 1'b0; i_clr_mask = '0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_counter_wrap();
    test_clear_collision();
    test_long_press();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/io_btn_event.md
IO_BTN_EVENT -- requirements
Module: io_btn_event

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 4: number of button channels.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of each per-button press counter.
REQ-003 The block SHALL have parameter LONG_MS, default 1000: long-press hold threshold in milliseconds.
REQ-004 The block SHALL have parameter CLK_PERIOD_NS, default 20: clock period used to derive LONG_CYC = LONG_MS*1_000_000/CLK_PERIOD_NS.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; one clock, and all state is clocked on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_btn, input, NUM_BTN bits: debounced keys, active-low (0 = pressed), synchronous to i_clk.
REQ-008 The block SHALL have port i_clr_we, input, 1 bit: clear strobe from the CPU load/store path.
REQ-009 The block SHALL have port i_clr_mask, input, NUM_BTN bits: write-1-to-clear mask, qualified by i_clr_we.
REQ-010 The block SHALL have port o_btn_level, output, NUM_BTN bits: registered pressed state, active-high.
REQ-011 The block SHALL have port o_btn_press, output, NUM_BTN bits: sticky press-event flags.
REQ-012 The block SHALL have port o_btn_cnt, output, NUM_BTN*CNT_W bits: press counters, with button k in bits [k*CNT_W +: CNT_W].
REQ-013 The block SHALL have port o_btn_long, output, NUM_BTN bits: sticky long-press flags.

Function
REQ-014 Level: o_btn_level[k] SHALL equal ~i_btn[k] delayed by exactly one clock.
REQ-015 Press edge: a press edge on k SHALL be the combinational condition ~i_btn[k] & ~o_btn_level[k].
REQ-016 Press edge effect: a press edge SHALL set o_btn_press[k] and increment counter k on the same clock edge that o_btn_level[k] rises (1-cycle latency from i_btn falling).
REQ-017 Release edge: a release edge (i_btn[k]=1 while o_btn_level[k]=1) SHALL change neither flags nor counters.
REQ-018 Counter wrap: each counter SHALL wrap modulo 2^CNT_W (all-ones + press -> 0), with no saturation.
REQ-019 Counter clear: counters SHALL be cleared only by reset, never by i_clr_we.
REQ-020 Flag clear: when i_clr_we=1, every o_btn_press[k] and o_btn_long[k] with i_clr_mask[k]=1 SHALL clear on the next edge.
REQ-021 Clear without strobe: i_clr_mask SHALL be ignored when i_clr_we=0.
REQ-022 Set wins: if a set event and a clear for the same bit occur in the same cycle, the flag SHALL end at 1.
REQ-023 Channel independence: channels SHALL be fully independent, so simultaneous presses on several keys are each captured and counted once.
REQ-024 Pulse capture: a press lasting a single cycle SHALL still set the flag and increment the counter once.

Reset
REQ-025 While i_rst_n=0, o_btn_level, o_btn_press, all counters, o_btn_long and all internal hold timers SHALL be 0 asynchronously.
REQ-026 Reset deassertion: after i_rst_n deasserts, a key already held low SHALL produce one press event on the first clock edge.
REQ-027 Reset mid-hold: reset asserted mid-hold SHALL abort the hold timing, and timing SHALL restart from 0.

Configuration
REQ-028 Macro BTN_LONGPRESS_EN defined: each channel SHALL have a saturating hold timer, reset to 0 while o_btn_level[k]=0 and incremented each cycle while o_btn_level[k]=1.
REQ-029 Macro BTN_LONGPRESS_EN defined: o_btn_long[k] SHALL set on the edge where the timer reaches LONG_CYC, and SHALL set once per hold.
REQ-030 Macro BTN_LONGPRESS_EN defined: a long-press flag cleared during a continued hold SHALL NOT re-set until the key is released and held again.
REQ-031 Macro BTN_LONGPRESS_EN undefined: o_btn_long SHALL be constant 0, and no hold timers SHALL be synthesized.

Verification
REQ-032 The bench SHALL cover reset: hold i_rst_n=0 with i_btn=4'hF -> all outputs 0, and after release with no presses all outputs stay 0.
REQ-033 The bench SHALL cover a single press: drive i_btn[2]=0 for 5 cycles, then 1 -> o_btn_level=4'h4 for 5 cycles starting 1 cycle after, o_btn_press=4'h4, counter2=1, others 0.
REQ-034 The bench SHALL cover counter wrap: 256 separate presses of key0 with CNT_W=8 -> counter0=0 and o_btn_press[0]=1.
REQ-035 The bench SHALL cover clear/set collision: with o_btn_press=4'h3, pulse i_clr_we with mask 4'h3 in the same cycle as a key1 press edge -> o_btn_press=4'h2.
REQ-036 The bench SHALL cover long-press: with BTN_LONGPRESS_EN, LONG_MS=1, CLK_PERIOD_NS=100000 (LONG_CYC=10), hold key3 for 12 cycles -> o_btn_long[3] rises exactly 10 cycles after o_btn_level[3]; hold 9 cycles -> stays 0.
REQ-037 The bench SHALL cover the build without the macro: repeat the long-press scenario without BTN_LONGPRESS_EN -> o_btn_long=0 throughout, and the press and counter results are unchanged.
